// File: rtl/noc_output_block.sv
// Output block of a NoC router: arbitrates packet requests from the five
// input directions (xp, xm, yp, ym, l) with a round-robin pointer, holds
// the grant from head to tail flit, and forwards the owner's flits through
// a one-entry registered output stage onto the output link.
module noc_output_block #(
   parameter int         FLIT_WIDTH      = 64,
   parameter logic [4:0] AVAILABLE_PORTS = 5'b11111
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4:0]              i_request,
   output logic [4:0]              o_grant,
   input  logic [4:0]              i_valid,
   output logic [4:0]              o_ready,
   input  logic [5*FLIT_WIDTH-1:0] i_flit,
   input  logic [4:0]              i_tail,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [FLIT_WIDTH-1:0]   o_flit,
   output logic                    o_tail
);

   localparam int NPORTS = 5;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                  state;
   state_t                  state_n;
   logic [NPORTS-1:0]       grant;
   logic [NPORTS-1:0]       grant_n;
   logic [2:0]              ptr;
   logic [2:0]              ptr_n;
   logic [NPORTS-1:0]       req_eff;
   logic                    found;
   logic                    stage_free;
   logic                    xfer;
   logic                    sel_valid;
   logic                    sel_tail;
   logic [FLIT_WIDTH-1:0]   sel_flit;

   // Disabled requesters can never win, so they never see grant or ready.
   assign req_eff = i_request & AVAILABLE_PORTS;

   // The output stage can accept a flit when empty or draining this cycle.
   assign stage_free = !o_valid || i_ready;

   // grant is all-zero in IDLE, so only the BUSY owner can see ready, and
   // ready never depends on i_valid.
   assign o_ready = grant & {NPORTS{stage_free}};
   assign o_grant = grant;

   // Select the owner's valid, tail and flit using the one-hot grant.
   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      sel_valid = 1'b0;
      sel_tail  = 1'b0;
      sel_flit  = '0;
      for (int i = 0; i < NPORTS; i++) begin
         if (grant[i]) begin
            sel_valid = i_valid[i];
            sel_tail  = i_tail[i];
            sel_flit  = i_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
         end
      end
   end

   assign xfer = (state == BUSY) && sel_valid && stage_free;

   // Next state: round-robin pick in IDLE, release and advance pointer on tail.
   always_comb begin
      state_n = state;
      grant_n = grant;
      ptr_n   = ptr;
      found   = 1'b0;
      case (state)
         IDLE: begin
            grant_n = '0;
            for (int p = 0; p < NPORTS; p++) begin
               if (ptr == 3'(p)) begin
                  for (int k = 0; k < NPORTS; k++) begin
                     if (!found && req_eff[(p + k) % NPORTS]) begin
                        found                        = 1'b1;
                        grant_n[(p + k) % NPORTS]    = 1'b1;
                     end
                  end
               end
            end
            if (found) begin
               state_n = BUSY;
            end
         end
         BUSY: begin
            if (xfer && sel_tail) begin
               state_n = IDLE;
               grant_n = '0;
               for (int i = 0; i < NPORTS; i++) begin
                  if (grant[i]) begin
                     ptr_n = 3'((i + 1) % NPORTS);
                  end
               end
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase
   end

   // Arbitration state register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= '0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         ptr   <= ptr_n;
      end
   end

   // One-entry output stage: load on owner transfer, clear when drained.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid <= 1'b0;
         o_flit  <= '0;
         o_tail  <= 1'b0;
      end else if (xfer) begin
         o_valid <= 1'b1;
         o_flit  <= sel_flit;
         o_tail  <= sel_tail;
      end else if (o_valid && i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_noc_output_block.sv
// Self-checking bench for noc_output_block: two instances (all ports
// enabled, and ports 10110 only) share stimulus and are compared every
// cycle against a packet-level behavioural model, plus literal checks.
module tb_noc_output_block;

   localparam int         FW     = 32;
   localparam logic [4:0] MASK_A = 5'b11111;
   localparam logic [4:0] MASK_B = 5'b10110;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst       = 1'b1;
   logic [4:0]      i_request = '0;
   logic [4:0]      i_valid   = '0;
   logic [4:0]      i_tail    = '0;
   logic [5*FW-1:0] i_flit    = '0;
   logic            i_ready   = 1'b1;

   logic [4:0]    o_grant_a, o_ready_a, o_grant_b, o_ready_b;
   logic          o_valid_a, o_tail_a, o_valid_b, o_tail_b;
   logic [FW-1:0] o_flit_a, o_flit_b;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [4:0] gq_a[$];
   logic [4:0] gq_b[$];

   noc_output_block #(.FLIT_WIDTH(FW), .AVAILABLE_PORTS(MASK_A)) dut_a (
      .clk(clk), .rst(rst), .i_request(i_request), .o_grant(o_grant_a),
      .i_valid(i_valid), .o_ready(o_ready_a), .i_flit(i_flit), .i_tail(i_tail),
      .o_valid(o_valid_a), .i_ready(i_ready), .o_flit(o_flit_a), .o_tail(o_tail_a));

   noc_output_block #(.FLIT_WIDTH(FW), .AVAILABLE_PORTS(MASK_B)) dut_b (
      .clk(clk), .rst(rst), .i_request(i_request), .o_grant(o_grant_b),
      .i_valid(i_valid), .o_ready(o_ready_b), .i_flit(i_flit), .i_tail(i_tail),
      .o_valid(o_valid_b), .i_ready(i_ready), .o_flit(o_flit_b), .o_tail(o_tail_b));

   // ---------------- behavioural model ----------------
   typedef struct packed {
      int            owner;   // -1 when no packet is granted
      int            ptr;
      logic          ov;
      logic [FW-1:0] flit;
      logic          tail;
   } mdl_t;

   mdl_t ma, mb;

   function automatic logic bit_of(logic [4:0] v, int p);
      return ((v >> p) & 5'd1) != 5'd0;
   endfunction

   function automatic logic [4:0] put_bit(logic [4:0] v, int p, logic b);
      return (v & ~(5'd1 << p)) | ({4'd0, b} << p);
   endfunction

   function automatic logic [5*FW-1:0] put_flit(logic [5*FW-1:0] v, int p, logic [FW-1:0] f);
      logic [5*FW-1:0] m;
      m = {{(4*FW){1'b0}}, {FW{1'b1}}};
      return (v & ~(m << (p*FW))) | ({{(4*FW){1'b0}}, f} << (p*FW));
   endfunction

   function automatic logic [FW-1:0] flit_of(int p);
      return FW'(i_flit >> (p*FW));
   endfunction

   function automatic logic [FW-1:0] mk_flit(int p, int pkt, int cnt);
      return {8'(p), 8'(pkt), 16'(cnt)};
   endfunction

   // One clock of the output block's rules, applied to the sampled inputs.
   function automatic mdl_t mstep(mdl_t m, logic [4:0] mask);
      mdl_t n;
      logic xfer;
      int   c;
      n    = m;
      xfer = 1'b0;
      if (rst) begin
         n.owner = -1; n.ptr = 0; n.ov = 1'b0; n.flit = '0; n.tail = 1'b0;
         return n;
      end
      if (m.owner >= 0) begin
         xfer = bit_of(i_valid, m.owner) && (!m.ov || i_ready);
         if (xfer) begin
            n.ov   = 1'b1;
            n.flit = flit_of(m.owner);
            n.tail = bit_of(i_tail, m.owner);
            if (bit_of(i_tail, m.owner)) begin
               n.owner = -1;
               n.ptr   = (m.owner + 1) % 5;
            end
         end
      end else begin
         for (int k = 0; k < 5; k++) begin
            c = (m.ptr + k) % 5;
            if (n.owner < 0 && bit_of(i_request & mask, c)) n.owner = c;
         end
      end
      if (!xfer && m.ov && i_ready) n.ov = 1'b0;
      return n;
   endfunction

   function automatic logic [4:0] exp_grant(mdl_t m);
      return (m.owner < 0) ? 5'd0 : (5'd1 << m.owner);
   endfunction

   function automatic logic [4:0] exp_ready(mdl_t m);
      return (m.owner >= 0 && (!m.ov || i_ready)) ? exp_grant(m) : 5'd0;
   endfunction

   // Advance both models on every clock edge.
   always @(posedge clk) begin
      ma <= mstep(ma, MASK_A);
      mb <= mstep(mb, MASK_B);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Compare both DUTs to the model away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("a_grant", o_grant_a, exp_grant(ma));
         check("a_ready", o_ready_a, exp_ready(ma));
         check("a_valid", o_valid_a, ma.ov);
         check("a_flit",  o_flit_a,  ma.flit);
         check("a_tail",  o_tail_a,  ma.tail);
         check("b_grant", o_grant_b, exp_grant(mb));
         check("b_ready", o_ready_b, exp_ready(mb));
         check("b_valid", o_valid_b, mb.ov);
         check("b_flit",  o_flit_b,  mb.flit);
         check("b_tail",  o_tail_b,  mb.tail);
         check("b_masked_ports", {o_grant_b & ~MASK_B, o_ready_b & ~MASK_B}, 64'd0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; i_request = '0; i_valid = '0; i_tail = '0; i_flit = '0; i_ready = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Protocol-following sources: each requester in reqm streams packets of
   // len flits, advancing when the chosen DUT showed it ready before the edge.
   task automatic run_sources(input logic [4:0] reqm, input int len, input int ncyc,
                              input int mode, input int stall_at, input bit use_b,
                              output int n_out);
      int            cnt[5];
      int            pkt[5];
      int            single;
      int            nout;
      logic [4:0]    rdy;
      logic [4:0]    prev_a, prev_b;
      logic [FW-1:0] held;
      for (int i = 0; i < 5; i++) begin cnt[i] = 0; pkt[i] = 0; end
      single = -1;
      if ($countones(reqm) == 1)
         for (int i = 0; i < 5; i++) if (bit_of(reqm, i)) single = i;
      nout = 0; held = '0;
      prev_a = o_grant_a; prev_b = o_grant_b;
      gq_a.delete(); gq_b.delete();
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         if (mode == 1)      i_ready = ($urandom_range(0, 3) != 0);
         else if (mode == 2) i_ready = !(cyc >= stall_at && cyc < stall_at + 4);
         else                i_ready = 1'b1;
         i_request = reqm; i_valid = reqm; i_tail = '0;
         for (int p = 0; p < 5; p++) begin
            if (bit_of(reqm, p)) begin
               i_flit = put_flit(i_flit, p, mk_flit(p, pkt[p], cnt[p]));
               i_tail = put_bit(i_tail, p, cnt[p] == len - 1);
            end
         end
         #1;
         rdy = use_b ? o_ready_b : o_ready_a;
         if (mode == 2 && cyc >= stall_at && cyc < stall_at + 4) begin
            if (cyc == stall_at) held = o_flit_a;
            else                 check("stall_flit_hold", o_flit_a, held);
            check("stall_valid", o_valid_a, 1'b1);
            check("stall_ready", o_ready_a & reqm, 5'd0);
            check("stall_grant", o_grant_a, reqm);
         end
         if (single >= 0 && !use_b && o_valid_a && i_ready) begin
            check("seq_flit", o_flit_a, mk_flit(single, nout / len, nout % len));
            nout++;
         end
         tick();
         for (int p = 0; p < 5; p++) begin
            if (bit_of(rdy, p) && bit_of(reqm, p)) begin
               cnt[p]++;
               if (cnt[p] == len) begin cnt[p] = 0; pkt[p]++; end
            end
         end
         if (o_grant_a != 5'd0 && prev_a == 5'd0) gq_a.push_back(o_grant_a);
         if (o_grant_b != 5'd0 && prev_b == 5'd0) gq_b.push_back(o_grant_b);
         prev_a = o_grant_a; prev_b = o_grant_b;
      end
      i_request = '0; i_valid = '0; i_tail = '0; i_ready = 1'b1;
      n_out = nout;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int            nout;
      logic [4:0]    ord_a[6];
      logic [4:0]    ord_b[4];
      ord_a = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
      ord_b = '{5'b00010, 5'b00100, 5'b10000, 5'b00010};

      do_reset();
      check("reset_grant", o_grant_a, 5'd0);
      check("reset_valid", o_valid_a, 1'b0);
      check("reset_flit",  o_flit_a,  '0);

      // 3-flit packet from xp with the link always ready.
      i_request = 5'b00001;
      check("t1_no_grant_yet", o_grant_a, 5'd0);
      tick();
      check("t1_grant", o_grant_a, 5'b00001);
      i_valid = 5'b00001; i_flit = put_flit(i_flit, 0, 'hA0);
      #1;
      check("t1_ready", o_ready_a, 5'b00001);
      check("t1_valid_before", o_valid_a, 1'b0);
      tick();
      check("t1_out_a0", o_flit_a, 'hA0); check("t1_v0", o_valid_a, 1'b1); check("t1_t0", o_tail_a, 1'b0);
      i_flit = put_flit(i_flit, 0, 'hA1);
      tick();
      check("t1_out_a1", o_flit_a, 'hA1); check("t1_t1", o_tail_a, 1'b0);
      i_flit = put_flit(i_flit, 0, 'hA2); i_tail = 5'b00001; i_request = 5'b00000;
      tick();
      check("t1_out_a2", o_flit_a, 'hA2); check("t1_t2", o_tail_a, 1'b1);
      check("t1_grant_released", o_grant_a, 5'd0);
      i_valid = '0; i_tail = '0;
      tick();
      check("t1_drained", o_valid_a, 1'b0);

      // Reset mid-packet from xm; pointer was 1, so xp must win afterwards.
      i_request = 5'b00010;
      tick();
      check("t6_grant_xm", o_grant_a, 5'b00010);
      i_valid = 5'b00010;
      for (int f = 0; f < 2; f++) begin
         i_flit = put_flit(i_flit, 1, FW'('hB0 + f));
         tick();
      end
      i_flit = put_flit(i_flit, 1, 'hB2);
      check("t6_staged_valid", o_valid_a, 1'b1);
      check("t6_staged_flit", o_flit_a, 'hB1);
      rst = 1'b1;
      tick();
      check("t6_rst_valid", o_valid_a, 1'b0);
      check("t6_rst_grant", o_grant_a, 5'd0);
      rst = 1'b0; i_valid = '0; i_request = 5'b00011;
      tick();
      check("t6_ptr_zero_xp", o_grant_a, 5'b00001);

      // Single-flit packets: xp, then l, then the pointer wraps back to xp.
      i_request = '0; i_valid = 5'b00001; i_tail = 5'b00001; i_flit = put_flit(i_flit, 0, 'hC0);
      tick();
      check("t5_xp_release", o_grant_a, 5'd0);
      check("t5_xp_flit", o_flit_a, 'hC0);
      i_valid = '0; i_tail = '0; i_request = 5'b10000;
      tick();
      check("t5_grant_l", o_grant_a, 5'b10000);
      i_request = '0; i_valid = 5'b10000; i_tail = 5'b10000; i_flit = put_flit(i_flit, 4, 'hD0);
      tick();
      check("t5_l_release", o_grant_a, 5'd0);
      check("t5_l_flit", o_flit_a, 'hD0);
      check("t5_l_tail", o_tail_a, 1'b1);
      i_valid = '0; i_tail = '0; i_request = 5'b01111;
      tick();
      check("t5_wrap_to_xp", o_grant_a, 5'b00001);
      i_request = '0; i_valid = 5'b00001; i_tail = 5'b00001; i_flit = put_flit(i_flit, 0, 'hE0);
      tick();
      i_valid = '0; i_tail = '0;
      tick();

      // All five requesting 2-flit packets: strict round-robin order.
      do_reset();
      run_sources(5'b11111, 2, 40, 0, 0, 1'b0, nout);
      check("t2_order_count", gq_a.size() >= 6, 1'b1);
      for (int i = 0; i < 6; i++)
         if (i < gq_a.size()) check("t2_order", gq_a[i], ord_a[i]);

      // Masked instance driven by its own handshakes.
      do_reset();
      run_sources(5'b11111, 2, 40, 0, 0, 1'b1, nout);
      check("t4_order_count", gq_b.size() >= 4, 1'b1);
      for (int i = 0; i < 4; i++)
         if (i < gq_b.size()) check("t4_order", gq_b[i], ord_b[i]);

      // yp owner with a 4-cycle link stall mid-packet.
      do_reset();
      run_sources(5'b00100, 6, 20, 2, 3, 1'b0, nout);
      check("t3_flits_out", nout, 12);

      // Random link backpressure with all requesters streaming.
      do_reset();
      run_sources(5'b11111, 3, 300, 1, 0, 1'b0, nout);
      do_reset();
      run_sources(5'b11111, 3, 300, 1, 0, 1'b1, nout);

      // Unconstrained random inputs, including occasional resets.
      do_reset();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         rst       = ($urandom_range(0, 149) == 0);
         i_request = 5'($urandom);
         i_valid   = 5'($urandom);
         i_tail    = 5'($urandom) & 5'($urandom);
         i_ready   = ($urandom_range(0, 3) != 0);
         for (int p = 0; p < 5; p++) i_flit = put_flit(i_flit, p, FW'($urandom));
         tick();
      end
      do_reset();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
